// File: rtl/load_ext_unit_pkg.sv
// Shared control encodings for the load extension unit: access size and extension mode codes.
// Optional feature macro used by this slice: LOAD_EXT_MISALIGN_CHK_EN.
package load_ext_unit_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic {
        EXT_ZERO   = 1'b0,
        EXT_SIGNED = 1'b1
    } ext_e;

    // A dword request on a 32-bit datapath degrades to a word access.
    function automatic size_e eff_size(input logic [1:0] size, input int unsigned dw);
        if (size == SZ_D && dw == 32) return SZ_W;
        return size_e'(size);
    endfunction

endpackage

// File: rtl/load_ext_field.sv
// Combinational field extraction and zero/sign extension of one raw memory word.
// With LOAD_EXT_MISALIGN_CHK_EN defined, misaligned offsets are flagged and yield zero.
module load_ext_field
    import load_ext_unit_pkg::*;
#(
    parameter int DW   = 32,
    parameter int OFFW = $clog2(DW/8)
) (
    input  logic [DW-1:0]   data_i,
    input  logic [OFFW-1:0] off_i,
    input  logic [1:0]      size_i,
    input  logic            ext_i,
    output logic [DW-1:0]   field_o
`ifdef LOAD_EXT_MISALIGN_CHK_EN
    ,
    output logic            misalign_o
`endif
);

    size_e           sz;
    logic [OFFW-1:0] amask;
    logic [OFFW-1:0] off_eff;
    logic [DW-1:0]   sh;
    logic [DW-1:0]   res;
    logic            sgn;

    always_comb begin
        sz  = eff_size(size_i, DW);
        sgn = (ext_i == EXT_SIGNED);
        unique case (sz)
            SZ_B:    amask = '0;
            SZ_H:    amask = OFFW'(1);
            SZ_W:    amask = OFFW'(3);
            default: amask = OFFW'(7);
        endcase
`ifdef LOAD_EXT_MISALIGN_CHK_EN
        off_eff = off_i;
`else
        // Low offset bits below the access size are ignored rather than flagged.
        off_eff = off_i & ~amask;
`endif
        sh = data_i >> {off_eff, 3'b000};
        unique case (sz)
            SZ_B:    res = sgn ? DW'($signed(sh[7:0]))  : DW'(sh[7:0]);
            SZ_H:    res = sgn ? DW'($signed(sh[15:0])) : DW'(sh[15:0]);
            SZ_W:    res = sgn ? DW'($signed(sh[31:0])) : DW'(sh[31:0]);
            default: res = sh;
        endcase
`ifdef LOAD_EXT_MISALIGN_CHK_EN
        misalign_o = |(off_i & amask);
        field_o    = misalign_o ? '0 : res;
`else
        field_o    = res;
`endif
    end

endmodule

// File: rtl/load_ext_unit.sv
// Load extension unit: extends loaded fields at accept time and buffers them in a two-entry skid stage.
// Optional LOAD_EXT_MISALIGN_CHK_EN adds the out_misalign output.
module load_ext_unit
    import load_ext_unit_pkg::*;
#(
    parameter int DW   = 32,
    parameter int OFFW = $clog2(DW/8)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [OFFW-1:0] in_off,
    input  logic [1:0]      in_size,
    input  logic            in_ext,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      count
`ifdef LOAD_EXT_MISALIGN_CHK_EN
    ,
    output logic            out_misalign
`endif
);

    logic          or_valid_q, or_valid_d;
    logic          sr_valid_q, sr_valid_d;
    logic [DW-1:0] or_data_q,  or_data_d;
    logic [DW-1:0] sr_data_q,  sr_data_d;
    logic [DW-1:0] field;
    logic          accept;
    logic          or_free;
`ifdef LOAD_EXT_MISALIGN_CHK_EN
    logic          or_mis_q, or_mis_d;
    logic          sr_mis_q, sr_mis_d;
    logic          field_mis;
`endif

    load_ext_field #(.DW(DW)) u_field (
        .data_i     (in_data),
        .off_i      (in_off),
        .size_i     (in_size),
        .ext_i      (in_ext),
        .field_o    (field)
`ifdef LOAD_EXT_MISALIGN_CHK_EN
        ,
        .misalign_o (field_mis)
`endif
    );

    // in_ready depends only on the skid flag, so out_ready never reaches it combinationally.
    assign in_ready  = !sr_valid_q;
    assign accept    = in_valid && in_ready;
    assign or_free   = !or_valid_q || out_ready;
    assign out_valid = or_valid_q;
    assign out_data  = or_data_q;
    assign count     = {1'b0, or_valid_q} + {1'b0, sr_valid_q};
`ifdef LOAD_EXT_MISALIGN_CHK_EN
    assign out_misalign = or_mis_q;
`endif

    always_comb begin
        or_valid_d = or_valid_q;
        sr_valid_d = sr_valid_q;
        or_data_d  = or_data_q;
        sr_data_d  = sr_data_q;
`ifdef LOAD_EXT_MISALIGN_CHK_EN
        or_mis_d   = or_mis_q;
        sr_mis_d   = sr_mis_q;
`endif
        if (flush) begin
            or_valid_d = 1'b0;
            sr_valid_d = 1'b0;
        end else if (or_free) begin
            if (sr_valid_q) begin
                or_valid_d = 1'b1;
                or_data_d  = sr_data_q;
                sr_valid_d = accept;
                if (accept) sr_data_d = field;
`ifdef LOAD_EXT_MISALIGN_CHK_EN
                or_mis_d = sr_mis_q;
                if (accept) sr_mis_d = field_mis;
`endif
            end else begin
                or_valid_d = accept;
                if (accept) or_data_d = field;
`ifdef LOAD_EXT_MISALIGN_CHK_EN
                if (accept) or_mis_d = field_mis;
`endif
            end
        end else if (accept) begin
            sr_valid_d = 1'b1;
            sr_data_d  = field;
`ifdef LOAD_EXT_MISALIGN_CHK_EN
            sr_mis_d   = field_mis;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            or_valid_q <= 1'b0;
            sr_valid_q <= 1'b0;
            or_data_q  <= '0;
            sr_data_q  <= '0;
`ifdef LOAD_EXT_MISALIGN_CHK_EN
            or_mis_q   <= 1'b0;
            sr_mis_q   <= 1'b0;
`endif
        end else begin
            or_valid_q <= or_valid_d;
            sr_valid_q <= sr_valid_d;
            or_data_q  <= or_data_d;
            sr_data_q  <= sr_data_d;
`ifdef LOAD_EXT_MISALIGN_CHK_EN
            or_mis_q   <= or_mis_d;
            sr_mis_q   <= sr_mis_d;
`endif
        end
    end

endmodule

// File: tb/tb_load_ext_unit.sv
// Self-checking bench for load_ext_unit: DW=32 and DW=64 instances in lock-step against a two-deep queue model.
module tb_load_ext_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic        ext = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] d32 = '0;
    logic [1:0]  o32 = '0;
    logic [63:0] d64 = '0;
    logic [2:0]  o64 = '0;

    logic        rdy32, ov32, rdy64, ov64;
    logic [31:0] od32;
    logic [63:0] od64;
    logic [1:0]  cnt32, cnt64;
`ifdef LOAD_EXT_MISALIGN_CHK_EN
    logic        mis32, mis64;
`endif

    int checks = 0;
    int errors = 0;
    logic [64:0] q32[$];
    logic [64:0] q64[$];

    always #5 clk = ~clk;

    load_ext_unit #(.DW(32)) u_dut32 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy32),
        .in_data(d32), .in_off(o32), .in_size(size), .in_ext(ext), .flush(flush),
        .out_valid(ov32), .out_ready(out_ready), .out_data(od32), .count(cnt32)
`ifdef LOAD_EXT_MISALIGN_CHK_EN
        , .out_misalign(mis32)
`endif
    );

    load_ext_unit #(.DW(64)) u_dut64 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy64),
        .in_data(d64), .in_off(o64), .in_size(size), .in_ext(ext), .flush(flush),
        .out_valid(ov64), .out_ready(out_ready), .out_data(od64), .count(cnt64)
`ifdef LOAD_EXT_MISALIGN_CHK_EN
        , .out_misalign(mis64)
`endif
    );

    // Reference entry {misaligned, extended value} computed from byte arithmetic.
    function automatic logic [64:0] ref_entry(input logic [63:0] data, input int unsigned off,
                                              input logic [1:0] sz, input logic e, input int unsigned dw);
        int unsigned nb;
        int unsigned o;
        logic [63:0] mask;
        logic [63:0] f;
        logic        mis;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2 || dw == 32) ? 4 : 8;
        mis = (off % nb) != 0;
`ifdef LOAD_EXT_MISALIGN_CHK_EN
        o = off;
`else
        o = off - (off % nb);
`endif
        f = data >> (8 * o);
        mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        f = f & mask;
        if (e && f[8 * nb - 1]) f = f | ~mask;
        if (dw == 32) f = f & 64'h0000_0000_FFFF_FFFF;
`ifdef LOAD_EXT_MISALIGN_CHK_EN
        if (mis) f = '0;
`endif
        return {mis, f};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("ov32",  64'(ov32),  64'(q32.size() > 0));
        chk("cnt32", 64'(cnt32), 64'(q32.size()));
        chk("rdy32", 64'(rdy32), 64'(q32.size() < 2));
        chk("ov64",  64'(ov64),  64'(q64.size() > 0));
        chk("cnt64", 64'(cnt64), 64'(q64.size()));
        chk("rdy64", 64'(rdy64), 64'(q64.size() < 2));
        if (q32.size() > 0) chk("od32", 64'(od32), q32[0][63:0]);
        if (q64.size() > 0) chk("od64", od64, q64[0][63:0]);
`ifdef LOAD_EXT_MISALIGN_CHK_EN
        if (q32.size() > 0) chk("mis32", 64'(mis32), 64'(q32[0][64]));
        if (q64.size() > 0) chk("mis64", 64'(mis64), 64'(q64[0][64]));
`endif
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic step();
        logic acc32, fire32, acc64, fire64;
        logic [64:0] r32, r64;
        #1 check_state();
        acc32  = in_valid && (q32.size() < 2);
        fire32 = out_ready && (q32.size() > 0);
        acc64  = in_valid && (q64.size() < 2);
        fire64 = out_ready && (q64.size() > 0);
        r32 = ref_entry({32'b0, d32}, o32, size, ext, 32);
        r64 = ref_entry(d64, o64, size, ext, 64);
        @(posedge clk);
        if (flush) begin
            q32.delete();
            q64.delete();
        end else begin
            if (fire32) void'(q32.pop_front());
            if (acc32) q32.push_back(r32);
            if (fire64) void'(q64.pop_front());
            if (acc64) q64.push_back(r64);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [1:0] ao,
                         input logic [63:0] b, input logic [2:0] bo, input logic [1:0] s, input logic e);
        in_valid = v; d32 = a; o32 = ao; d64 = b; o64 = bo; size = s; ext = e;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ov32",  64'(ov32),  64'd0);
        chk("rst_rdy32", 64'(rdy32), 64'd1);
        chk("rst_cnt32", 64'(cnt32), 64'd0);
        chk("rst_od32",  64'(od32),  64'd0);
        chk("rst_od64",  od64,       64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Byte sign/zero extension, then halfword, then a 64-bit word32 access.
        out_ready = 1'b1;
        drive(1'b1, 32'h8765_43F0, 2'd0, 64'h8765_43F0, 3'd0, 2'b00, 1'b1);
        step();
        chk("byte_sext", 64'(od32), 64'h0000_0000_FFFF_FFF0);
        drive(1'b1, 32'h8765_43F0, 2'd0, 64'h8765_43F0, 3'd0, 2'b00, 1'b0);
        step();
        chk("byte_zext", 64'(od32), 64'h0000_0000_0000_00F0);
        drive(1'b1, 32'h8001_7FFF, 2'd2, 64'h8001_7FFF, 3'd2, 2'b01, 1'b1);
        step();
        chk("half_sext", 64'(od32), 64'h0000_0000_FFFF_8001);
        drive(1'b1, 32'h8001_7FFF, 2'd1, 64'h8001_7FFF, 3'd1, 2'b01, 1'b1);
        step();
`ifdef LOAD_EXT_MISALIGN_CHK_EN
        chk("half_mis_flag", 64'(mis32), 64'd1);
        chk("half_mis_data", 64'(od32),  64'd0);
`else
        chk("half_masked", 64'(od32), 64'h0000_0000_0000_7FFF);
`endif
        drive(1'b1, 32'h1234_5678, 2'd0, 64'h8000_0000_1234_5678, 3'd4, 2'b10, 1'b1);
        step();
        chk("w32_sext64", od64, 64'hFFFF_FFFF_8000_0000);
        drive(1'b0, '0, '0, '0, '0, 2'b00, 1'b0);
        step();

        // Stall: three back-to-back requests, two held, then in-order drain.
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0011, 2'd0, 64'h11, 3'd0, 2'b00, 1'b0);
        step();
        drive(1'b1, 32'h0000_0022, 2'd0, 64'h22, 3'd0, 2'b00, 1'b0);
        step();
        chk("full_cnt", 64'(cnt32), 64'd2);
        chk("full_rdy", 64'(rdy32), 64'd0);
        drive(1'b1, 32'h0000_0033, 2'd0, 64'h33, 3'd0, 2'b00, 1'b0);
        step();
        chk("stall_od", 64'(od32), 64'h11);
        drive(1'b0, '0, '0, '0, '0, 2'b00, 1'b0);
        out_ready = 1'b1;
        step();
        chk("drain_2nd", 64'(od32), 64'h22);
        step();
        step();

        // Flush with both entries full and a request presented.
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_00A1, 2'd0, 64'hA1, 3'd0, 2'b00, 1'b0);
        step();
        step();
        flush = 1'b1;
        drive(1'b1, 32'h0000_00B2, 2'd0, 64'hB2, 3'd0, 2'b00, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, '0, 2'b00, 1'b0);
        chk("flush_cnt", 64'(cnt32), 64'd0);
        chk("flush_ov",  64'(ov32),  64'd0);
        out_ready = 1'b1;
        step();
        step();

        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            d32  = $urandom;
            o32  = 2'($urandom);
            d64  = {$urandom, $urandom};
            o64  = 3'($urandom);
            size = 2'($urandom);
            ext  = 1'($urandom);
            step();
        end
        flush = 1'b0;

        // Asynchronous reset with two entries held.
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_00C3, 2'd0, 64'hC3, 3'd0, 2'b00, 1'b0);
        step();
        step();
        drive(1'b0, '0, '0, '0, '0, 2'b00, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_ov32",  64'(ov32),  64'd0);
        chk("arst_cnt32", 64'(cnt32), 64'd0);
        chk("arst_rdy32", 64'(rdy32), 64'd1);
        chk("arst_ov64",  64'(ov64),  64'd0);
        chk("arst_cnt64", 64'(cnt64), 64'd0);
        q32.delete();
        q64.delete();
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'hFF00_0080, 2'd0, 64'hFF00_0080, 3'd0, 2'b00, 1'b1);
        step();
        chk("post_rst", 64'(od32), 64'h0000_0000_FFFF_FF80);
        drive(1'b0, '0, '0, '0, '0, 2'b00, 1'b0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_ext_unit.md
LOAD_EXT_UNIT -- requirements
Module: load_ext_unit

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter OFFW, default $clog2(DW/8), byte-offset width, derived and not overridden.
REQ-003 SHALL have ports: clk input 1 system clock; rstn input 1 reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid input 1: request present.
REQ-005 SHALL have port in_ready output 1: request accepted when in_valid && in_ready.
REQ-006 SHALL have port in_data input DW: raw memory word.
REQ-007 SHALL have port in_off input OFFW: byte offset within word.
REQ-008 SHALL have port in_size input 2: 00 byte, 01 half, 10 word32, 11 dword (DW=64 only).
REQ-009 SHALL have port in_ext input 1: 0 zero-extend, 1 sign-extend.
REQ-010 SHALL have port flush input 1: synchronous discard of all held entries.
REQ-011 SHALL have ports out_valid output 1, out_ready input 1, out_data output DW, and count output 2 (entries held, 0..2).

Function
REQ-012 SHALL extract field = (in_data >> 8*in_off), truncated to the size width, then zero- or sign-extend it to DW per in_ext.
REQ-013 SHALL treat in_size=11 with DW=32 as word32.
REQ-014 SHALL treat in_size=10 with DW=64 as a sign- or zero-extended 32-bit field.
REQ-015 SHALL compute extension at accept time and store the result, not raw data.
REQ-016 SHALL hold two entries: output register OR (drives out_*) and skid register SR.
REQ-017 SHALL drive in_ready = !SR_valid from a register, with no combinational path from out_ready.
REQ-018 SHALL load an accepted request into OR when OR is empty, or when OR fires in the same cycle and SR is empty; otherwise it SHALL load SR.
REQ-019 SHALL move SR into OR when OR fires and SR is valid; a simultaneous accept SHALL then load SR.
REQ-020 SHALL give 1-cycle latency from accept to out_valid, with a sustained throughput of 1 per cycle while out_ready=1.
REQ-021 SHALL keep out_data and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL make count equal the number of valid entries, updated each cycle.
REQ-023 SHALL, on flush, clear OR_valid and SR_valid next cycle; flush SHALL override a simultaneous accept, and that request is dropped.

Reset
REQ-024 SHALL, while rstn=0, asynchronously force out_valid=0, in_ready=1, count=0, out_data=0 and both valid flags to 0.
REQ-025 SHALL, on reset mid-transfer, lose held entries; the first accept after rstn deasserts SHALL behave as from empty.

Configuration
REQ-026 SHALL, with macro LOAD_EXT_MISALIGN_CHK_EN defined, add output out_misalign 1 (registered with the entry) that is set when the offset is not a multiple of the size bytes; a misaligned entry SHALL produce out_data=0.
REQ-027 SHALL, without LOAD_EXT_MISALIGN_CHK_EN, omit the port and mask the offset down to size alignment before extraction.

Structure
REQ-028 SHALL place size codes (SZ_B, SZ_H, SZ_W, SZ_D) and extension codes (EXT_ZERO=0, EXT_SIGNED=1) in the shared control-encoding definitions header.
REQ-029 SHALL implement extraction and extension in one combinational sub-module, load_ext_field, instantiated once.

Verification
REQ-030 SHALL cover: DW=32, in_data=32'h8765_43F0, off=0, size=byte, ext=1 -> out_data=32'hFFFF_FFF0 one cycle after accept; with ext=0 -> 32'h0000_00F0.
REQ-031 SHALL cover: DW=32, in_data=32'h8001_7FFF, off=2, size=half, ext=1 -> 32'hFFFF_8001; with off=1 and macro defined -> out_misalign=1, out_data=0.
REQ-032 SHALL cover: DW=64, in_data=64'h8000_0000_1234_5678, off=4, size=word32, ext=1 -> 64'hFFFF_FFFF_8000_0000.
REQ-033 SHALL cover: out_ready=0 and three back-to-back requests -> two accepted, count=2, in_ready=0 on the third; then out_ready=1 -> in-order delivery, one per cycle.
REQ-034 SHALL cover: count=2 and flush=1 together with in_valid=1 -> next cycle count=0, out_valid=0, and the request is never output.
REQ-035 SHALL cover: rstn pulsed low asynchronously mid-stream -> out_valid and count drop immediately, in_ready=1.
